// File: rtl/fir_mac.sv
// Sequential one-tap-per-clock FIR multiply-accumulate stage.
// Produces a full-width signed sum for the downstream truncate/saturate stage.
module fir_mac #(
  parameter int unsigned cant_bits = 40,
  parameter int unsigned N_TAPS    = 4,
  parameter int unsigned COEF_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [cant_bits-33:0] x_in,
  input  logic [COEF_W*N_TAPS-1:0]     coef,
  output logic                         busy,
  output logic                         done,
  output logic signed [cant_bits-1:0]  y_out
);

  localparam int unsigned XW     = cant_bits - 32;
  localparam int unsigned PW     = XW + COEF_W;
  localparam int unsigned IdxW   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_TAPS - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                      state_q, state_d;
  logic signed [cant_bits-1:0] acc_q, acc_d;
  logic signed [cant_bits-1:0] y_q, y_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        done_q, done_d;
  logic                        shift_en;
  logic signed [XW-1:0]        x_q [N_TAPS];

  logic signed [XW-1:0]        x_sel;
  logic signed [COEF_W-1:0]    c_sel;
  logic signed [PW-1:0]        x_ext, c_ext, prod;

  // Operands widened to the full product width so the signed product is exact.
  always_comb begin
    x_sel = x_q[idx_q];
    c_sel = coef[COEF_W*idx_q +: COEF_W];
    x_ext = PW'(x_sel);
    c_ext = PW'(c_sel);
    prod  = x_ext * c_ext;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    y_d      = y_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_en = 1'b1;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + cant_bits'(prod);
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        y_d     = acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_TAPS); i++) x_q[i] <= '0;
    end else if (shift_en) begin
      x_q[0] <= x_in;
      for (int i = 1; i < int'(N_TAPS); i++) x_q[i] <= x_q[i-1];
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign y_out = y_q;

endmodule

// File: tb/tb_fir_mac.sv
// Self-checking bench for fir_mac: random samples and coefficients compared against
// a direct convolution model over a sample-history array.
module tb_fir_mac;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int W  = 40;
  localparam int XW = W - 32;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic signed [XW-1:0] x_in = '0;
  logic [CW*N-1:0]      coef = '0;
  logic                 busy;
  logic                 done;
  logic signed [W-1:0]  y_out;

  fir_mac #(
    .cant_bits(W),
    .N_TAPS   (N),
    .COEF_W   (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .x_in   (x_in),
    .coef   (coef),
    .busy   (busy),
    .done   (done),
    .y_out  (y_out)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     last_done_cyc = 0;
  longint hist [N];
  int     cf [N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint model_y();
    longint s = 0;
    for (int i = 0; i < N; i++) s += hist[i] * longint'(cf[i]);
    return s;
  endfunction

  task automatic load_coefs();
    for (int i = 0; i < N; i++) coef[CW*i +: CW] = cf[i][CW-1:0];
  endtask

  task automatic rand_coefs();
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r = CW'($urandom);
      cf[i] = $signed(r);
    end
    load_coefs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  // Pulse start at the current negedge and wait for done; optional ignored start at poke_cyc.
  task automatic run_start(input logic signed [XW-1:0] x, input int poke_cyc,
                           input logic signed [XW-1:0] poke_x, output longint got);
    longint              exp_y;
    logic signed [W-1:0] held;
    int                  lat;
    bit                  seen;
    held  = y_out;
    start = 1'b1;
    x_in  = x;
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    exp_y   = model_y();
    seen    = 1'b0;
    lat     = 0;
    for (int c = 1; c <= 3 * N + 10 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke_cyc) begin
        start = 1'b1;
        x_in  = poke_x;
      end
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        n_checks++;
        if (y_out !== held) begin
          n_errors++;
          $display("FAIL y_hold c=%0d got %0d required %0d", c, y_out, held);
        end
        if (c <= N + 1) begin
          n_checks++;
          if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_high c=%0d got %b required 1", c, busy);
          end
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL done_timeout got no done required done after %0d cycles", N + 2);
    end else begin
      n_checks++;
      if (lat != N + 2) begin
        n_errors++;
        $display("FAIL latency got %0d required %0d", lat, N + 2);
      end
      n_checks++;
      if (y_out !== W'(exp_y)) begin
        n_errors++;
        $display("FAIL y_out got %0d required %0d", y_out, exp_y);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_errors++;
        $display("FAIL busy_at_done got %b required 0", busy);
      end
    end
    last_done_cyc = cyc;
    got = y_out;
  endtask

  task automatic test_reset();
    longint got;
    apply_reset();
    n_checks++;
    if (y_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got y=%0d busy=%b done=%b required 0/0/0", y_out, busy, done);
    end
    rand_coefs();
    cf[0] = 256;
    load_coefs();
    run_start(8'sd5, 0, 8'sd0, got);
    n_checks++;
    if (got != 1280) begin
      n_errors++;
      $display("FAIL first_after_reset got %0d required 1280", got);
    end
  endtask

  task automatic test_impulse();
    longint got;
    int     exp_seq [N];
    exp_seq = '{256, 512, -256, 128};
    apply_reset();
    cf = '{256, 512, -256, 128};
    load_coefs();
    for (int k = 0; k < N; k++) begin
      run_start((k == 0) ? 8'sd1 : 8'sd0, 0, 8'sd0, got);
      n_checks++;
      if (got != longint'(exp_seq[k])) begin
        n_errors++;
        $display("FAIL impulse[%0d] got %0d required %0d", k, got, exp_seq[k]);
      end
    end
  endtask

  task automatic test_extremes();
    longint got;
    for (int i = 0; i < N; i++) cf[i] = 32767;
    load_coefs();
    for (int k = 0; k < N; k++) run_start(-8'sd128, 0, 8'sd0, got);
    n_checks++;
    if (got != -64'sd16776704) begin
      n_errors++;
      $display("FAIL extreme_pos_coef got %0d required -16776704", got);
    end
    for (int i = 0; i < N; i++) cf[i] = -32768;
    load_coefs();
    for (int k = 0; k < N; k++) run_start(-8'sd128, 0, 8'sd0, got);
    n_checks++;
    if (got != 64'sd16777216) begin
      n_errors++;
      $display("FAIL extreme_neg_coef got %0d required 16777216", got);
    end
  endtask

  task automatic test_busy_start();
    longint got;
    apply_reset();
    rand_coefs();
    // Pokes land in every MAC cycle and in the DONE cycle.
    for (int p = 1; p <= N + 1; p++) run_start(8'($urandom), p, 8'sd99, got);
    run_start(8'($urandom), 0, 8'sd0, got);
  endtask

  task automatic test_back_to_back();
    longint got;
    int     first_done;
    rand_coefs();
    run_start(8'($urandom), 0, 8'sd0, got);
    first_done = last_done_cyc;
    run_start(8'($urandom), 0, 8'sd0, got);
    n_checks++;
    if (last_done_cyc - first_done != N + 2) begin
      n_errors++;
      $display("FAIL back_to_back_gap got %0d required %0d", last_done_cyc - first_done, N + 2);
    end
  endtask

  task automatic test_reset_mid();
    longint got;
    bit     stray;
    rand_coefs();
    run_start(8'sd77, 0, 8'sd0, got);
    @(negedge clk);
    start = 1'b1;
    x_in  = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (y_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs got y=%0d busy=%b done=%b required 0/0/0", y_out, busy, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) hist[i] = 0;
    stray = 1'b0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin
      n_errors++;
      $display("FAIL mid_reset_no_done got done=1 required 0");
    end
    cf[0] = 256;
    load_coefs();
    run_start(8'sd5, 0, 8'sd0, got);
    n_checks++;
    if (got != 1280) begin
      n_errors++;
      $display("FAIL mid_reset_history got %0d required 1280", got);
    end
  endtask

  task automatic test_random();
    longint got;
    for (int k = 0; k < 24; k++) begin
      if (k % 8 == 0) rand_coefs();
      run_start(8'($urandom), int'($urandom_range(0, N + 1)), 8'($urandom), got);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hist[i] = 0;
      cf[i]   = 0;
    end
    test_reset();
    test_impulse();
    test_extremes();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
